// File: rtl/counter_pkg.sv
// Shared constants and helpers for the up/down modulo counter family.
package counter_pkg;

    localparam logic DIR_UP   = 1'b1;
    localparam logic DIR_DOWN = 1'b0;

    // Default single decimal/hex display digit.
    typedef logic [3:0] digit_t;

    // Prescaler register width: enough bits to hold 0..div_value, never zero.
    function automatic int presc_width(input int div_value);
        int w;
        w = $clog2(div_value + 1);
        return (w < 1) ? 1 : w;
    endfunction

endpackage

// File: rtl/tick_gen.sv
// Free-running prescaler; emits a registered one-cycle tick every DIV_VALUE+1 clocks.
module tick_gen
    import counter_pkg::*;
#(
    parameter int DIV_VALUE = 49999999
) (
    input  logic clk,
    input  logic reset,
    output logic tick
);

    localparam int PW = presc_width(DIV_VALUE);
    localparam logic [PW-1:0] DIV_TERM = PW'(DIV_VALUE);

    logic [PW-1:0] presc;
    logic [PW-1:0] presc_nxt;

    always_comb begin
        presc_nxt = (presc == DIV_TERM) ? '0 : presc + 1'b1;
    end

    // tick is registered against the next prescaler value so it is high
    // exactly while the prescaler sits at its terminal value.
    always_ff @(posedge clk) begin
        if (!reset) begin
            presc <= '0;
            tick  <= 1'b0;
        end else begin
            presc <= presc_nxt;
            tick  <= (presc_nxt == DIV_TERM);
        end
    end

endmodule

// File: rtl/up_down_counter_mod.sv
// Parametrised up/down modulo counter with load, enable, terminal-count pulse and prescaler tick.
// Define UDC_SATURATE_EN to pin at the range limits instead of wrapping.
module up_down_counter_mod
    import counter_pkg::*;
#(
    parameter int WIDTH     = 4,
    parameter int MOD_VALUE = 10,
    parameter int DIV_VALUE = 49999999
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             en,
    input  logic             ud,
    input  logic             load,
    input  logic [WIDTH-1:0] load_val,
    output logic [WIDTH-1:0] count,
    output logic             tc,
    output logic             tick
);

    // MOD_VALUE may equal 2**WIDTH, so only the top value is ever formed.
    localparam logic [WIDTH-1:0] MAX = WIDTH'(MOD_VALUE - 1);

    logic [WIDTH-1:0] load_clamp;

    tick_gen #(.DIV_VALUE(DIV_VALUE)) u_tick_gen (
        .clk   (clk),
        .reset (reset),
        .tick  (tick)
    );

    always_comb begin
        load_clamp = (load_val > MAX) ? MAX : load_val;
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            count <= '0;
            tc    <= 1'b0;
        end else if (load) begin
            count <= load_clamp;
            tc    <= 1'b0;
        end else if (tick && en) begin
            if (ud == DIR_UP) begin
                if (count == MAX) begin
`ifdef UDC_SATURATE_EN
                    count <= MAX;
`else
                    count <= '0;
`endif
                    tc    <= 1'b1;
                end else begin
                    count <= count + 1'b1;
                    tc    <= 1'b0;
                end
            end else begin
                if (count == '0) begin
`ifdef UDC_SATURATE_EN
                    count <= '0;
`else
                    count <= MAX;
`endif
                    tc    <= 1'b1;
                end else begin
                    count <= count - 1'b1;
                    tc    <= 1'b0;
                end
            end
        end else begin
            tc <= 1'b0;
        end
    end

endmodule

// File: tb/tb_up_down_counter_mod.sv
// Directed bench: WIDTH=4, MOD_VALUE=10, DIV_VALUE=3; expected outputs queued per cycle and checked by a monitor.
module tb_up_down_counter_mod;

    logic       clk = 1'b0;
    logic       reset = 1'b0;
    logic       en = 1'b0;
    logic       ud = 1'b1;
    logic       load = 1'b0;
    logic [3:0] load_val = '0;
    logic [3:0] count;
    logic       tc;
    logic       tick;

    typedef struct {
        logic [3:0] c;
        logic       tc;
        logic       tk;
    } exp_t;

    exp_t exp_q[$];
    int   checks = 0;
    int   errors = 0;

    up_down_counter_mod #(.WIDTH(4), .MOD_VALUE(10), .DIV_VALUE(3)) dut (
        .clk      (clk),
        .reset    (reset),
        .en       (en),
        .ud       (ud),
        .load     (load),
        .load_val (load_val),
        .count    (count),
        .tc       (tc),
        .tick     (tick)
    );

    always #5 clk = ~clk;

    // Monitor: outputs settle after the rising edge, compare on the falling edge.
    initial begin
        exp_t e;
        forever begin
            @(negedge clk);
            if (exp_q.size() > 0) begin
                e = exp_q.pop_front();
                checks++;
                if (count !== e.c) begin
                    errors++;
                    $display("FAIL count t=%0t got %0d want %0d", $time, count, e.c);
                end
                checks++;
                if (tc !== e.tc) begin
                    errors++;
                    $display("FAIL tc t=%0t got %0b want %0b", $time, tc, e.tc);
                end
                checks++;
                if (tick !== e.tk) begin
                    errors++;
                    $display("FAIL tick t=%0t got %0b want %0b", $time, tick, e.tk);
                end
            end
        end
    end

    // One clock: inputs held for the cycle, expected values are the outputs after its edge.
    task automatic cyc(input logic r, input logic e_n, input logic u, input logic ld,
                       input logic [3:0] lv, input logic [3:0] ec, input logic etc,
                       input logic etk);
        exp_t x;
        reset = r; en = e_n; ud = u; load = ld; load_val = lv;
        @(posedge clk);
        x.c = ec; x.tc = etc; x.tk = etk;
        exp_q.push_back(x);
        #1;
    endtask

    // One prescaler period starting on the tick cycle; ud is only honoured on that cycle.
    task automatic period(input logic e_n, input logic u, input logic [3:0] ec, input logic etc);
        cyc(1'b1, e_n, u,  1'b0, 4'd0, ec, etc,  1'b0);
        cyc(1'b1, e_n, !u, 1'b0, 4'd0, ec, 1'b0, 1'b0);
        cyc(1'b1, e_n, !u, 1'b0, 4'd0, ec, 1'b0, 1'b0);
        cyc(1'b1, e_n, !u, 1'b0, 4'd0, ec, 1'b0, 1'b1);
    endtask

    // Load on the tick cycle, then the rest of that period with no step.
    task automatic load_on_tick(input logic [3:0] lv, input logic [3:0] ec);
        cyc(1'b1, 1'b1, 1'b1, 1'b1, lv, ec, 1'b0, 1'b0);
        cyc(1'b1, 1'b1, 1'b1, 1'b0, 4'd0, ec, 1'b0, 1'b0);
        cyc(1'b1, 1'b1, 1'b1, 1'b0, 4'd0, ec, 1'b0, 1'b0);
        cyc(1'b1, 1'b1, 1'b1, 1'b0, 4'd0, ec, 1'b0, 1'b1);
    endtask

    task automatic release_seq();
        cyc(1'b1, 1'b1, 1'b1, 1'b0, 4'd0, 4'd0, 1'b0, 1'b0);
        cyc(1'b1, 1'b1, 1'b1, 1'b0, 4'd0, 4'd0, 1'b0, 1'b0);
        cyc(1'b1, 1'b1, 1'b1, 1'b0, 4'd0, 4'd0, 1'b0, 1'b1);
    endtask

    initial begin
        @(posedge clk);
        #1;
        // reset held two cycles
        cyc(1'b0, 1'b1, 1'b1, 1'b0, 4'd0, 4'd0, 1'b0, 1'b0);
        cyc(1'b0, 1'b1, 1'b1, 1'b0, 4'd0, 4'd0, 1'b0, 1'b0);
        release_seq();

        // count up 1..9 then wrap to 0 with tc
        for (int i = 1; i <= 9; i++) period(1'b1, 1'b1, 4'(i), 1'b0);
        period(1'b1, 1'b1, 4'd0, 1'b1);

        // down wrap, then direction follows ud only at tick
        period(1'b1, 1'b0, 4'd9, 1'b1);
        period(1'b1, 1'b1, 4'd0, 1'b1);
        period(1'b1, 1'b0, 4'd9, 1'b1);
        period(1'b1, 1'b0, 4'd8, 1'b0);
        period(1'b1, 1'b1, 4'd9, 1'b0);

        // load coincident with tick: no step, no tc
        load_on_tick(4'd7, 4'd7);
        // step then load 14 mid-prescale clamps to 9
        cyc(1'b1, 1'b1, 1'b1, 1'b0, 4'd0,  4'd8, 1'b0, 1'b0);
        cyc(1'b1, 1'b1, 1'b1, 1'b1, 4'd14, 4'd9, 1'b0, 1'b0);
        cyc(1'b1, 1'b1, 1'b1, 1'b0, 4'd0,  4'd9, 1'b0, 1'b0);
        cyc(1'b1, 1'b1, 1'b1, 1'b0, 4'd0,  4'd9, 1'b0, 1'b1);
        period(1'b1, 1'b1, 4'd0, 1'b1);
        // load applies with en low
        cyc(1'b1, 1'b0, 1'b1, 1'b0, 4'd0, 4'd0, 1'b0, 1'b0);
        cyc(1'b1, 1'b0, 1'b1, 1'b1, 4'd3, 4'd3, 1'b0, 1'b0);
        cyc(1'b1, 1'b0, 1'b1, 1'b0, 4'd0, 4'd3, 1'b0, 1'b0);
        cyc(1'b1, 1'b0, 1'b1, 1'b0, 4'd0, 4'd3, 1'b0, 1'b1);

        // en low across three ticks, then resume
        for (int i = 0; i < 3; i++) period(1'b0, 1'b1, 4'd3, 1'b0);
        period(1'b1, 1'b1, 4'd4, 1'b0);

        // reset on a tick cycle discards the tick and restarts the prescaler
        cyc(1'b0, 1'b1, 1'b1, 1'b0, 4'd0, 4'd0, 1'b0, 1'b0);
        release_seq();
        period(1'b1, 1'b1, 4'd1, 1'b0);

        // limit behaviour
        load_on_tick(4'd8, 4'd8);
        period(1'b1, 1'b1, 4'd9, 1'b0);
`ifdef UDC_SATURATE_EN
        period(1'b1, 1'b1, 4'd9, 1'b1);
        period(1'b1, 1'b1, 4'd9, 1'b1);
        load_on_tick(4'd1, 4'd1);
        period(1'b1, 1'b0, 4'd0, 1'b0);
        period(1'b1, 1'b0, 4'd0, 1'b1);
        period(1'b1, 1'b0, 4'd0, 1'b1);
`else
        period(1'b1, 1'b1, 4'd0, 1'b1);
        period(1'b1, 1'b1, 4'd1, 1'b0);
        load_on_tick(4'd1, 4'd1);
        period(1'b1, 1'b0, 4'd0, 1'b0);
        period(1'b1, 1'b0, 4'd9, 1'b1);
`endif

        for (int i = 0; i < 10 && exp_q.size() != 0; i++) @(negedge clk);
        #1;
        checks++;
        if (exp_q.size() != 0) begin
            errors++;
            $display("FAIL drain got %0d pending want 0", exp_q.size());
        end
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/up_down_counter_mod.md
Name: up_down_counter_mod

Overview:
Parametrised synchronous up/down modulo counter that generalises the team's fixed 4-bit counter. Width, modulus and prescale are parameters. Adds count enable, parallel load, a terminal-count pulse and an exported tick. Counting is clock-enable based: no derived clocks. Sits between the board clock and the seven-segment/display path, and can be chained through tc for multi-digit counts.

Parameters:
WIDTH, 4, counter width in bits (1..16)
MOD_VALUE, 10, modulus; count range 0..MOD_VALUE-1; 2 <= MOD_VALUE <= 2**WIDTH
DIV_VALUE, 49999999, prescaler terminal value; one tick every DIV_VALUE+1 clk cycles; 0 = tick every cycle

Ports:
clk  input  1  system clock; the only clock
reset  input  1  synchronous, active-low reset (0 = reset, sampled on posedge clk)
en  input  1  count enable; qualifies tick
ud  input  1  direction: 1 = up, 0 = down; sampled on tick
load  input  1  synchronous parallel load request
load_val  input  WIDTH  value for load
count  output  WIDTH  current count (registered)
tc  output  1  terminal-count pulse, one clk cycle wide (registered)
tick  output  1  prescaler tick, one clk cycle wide (registered)

Behaviour:
- Reset (reset==0 at posedge clk): count=0, tc=0, tick=0, prescaler=0. Overrides load and tick. Mid-operation reset discards any pending tick.
- Prescaler: free-runs 0..DIV_VALUE independent of en, ud and load. tick=1 on the cycle the prescaler equals DIV_VALUE, then the prescaler wraps to 0. First tick comes DIV_VALUE+1 cycles after reset release.
- Priority per cycle: reset > load > (tick & en) count step > hold.
- load=1: count <= min(load_val, MOD_VALUE-1), applied on the next edge regardless of tick or en. No tc is generated. A coincident tick is consumed without stepping.
- Step, on tick & en & !load:
  - up: count==MOD_VALUE-1 -> 0 with tc=1; otherwise count+1.
  - down: count==0 -> MOD_VALUE-1 with tc=1; otherwise count-1.
- tc goes high in the same cycle the wrapped count becomes visible and stays high for exactly one clk cycle. Otherwise tc=0.
- en=0: count holds and tc=0. The prescaler keeps running, so re-enabling resumes on the next natural tick.
- ud changes between ticks have no effect until the next tick.
- All arithmetic is WIDTH bits with explicit wrap compare. The count never leaves 0..MOD_VALUE-1, including when MOD_VALUE==2**WIDTH.
- Latency: count and tc update 1 clk after the qualifying tick/load cycle. Tick-to-count-change is 1 clk.

Optional Feature:
Macro UDC_SATURATE_EN.
- Defined: no wrap. Up at MOD_VALUE-1 holds; down at 0 holds. tc=1 on each qualifying tick while pinned at the limit in the current direction.
- Undefined: modulo wrap as in Behaviour; tc only on wrap.
- Load, reset and prescaler behaviour are identical either way.

Decomposition:
- Package counter_pkg: direction constants DIR_UP=1 and DIR_DOWN=0; a function computing the prescaler width as clog2(DIV_VALUE+1), minimum 1; a shared typedef for the default 4-bit digit.
- Sub-module tick_gen (parameter DIV_VALUE; ports clk, reset, tick) holds the prescaler.
- The counter core stays in up_down_counter_mod.

Test Plan:
- WIDTH=4, MOD=10, DIV=3; reset low for 2 cycles, then release -> count=0, tc=0, tick=0 during reset; first tick on 4th cycle after release; count=1 one cycle later.
- en=1, ud=1, 10 ticks from 0 -> count 1..9, then 0; tc high exactly one cycle, coincident with count==0.
- ud=0 from count 0 -> next tick gives count=9, tc pulse. Then ud toggled between ticks -> direction follows ud at each tick only.
- load=1, load_val=7 mid-prescale -> count=7 next cycle, no tc. load_val=14 -> count=9. load coincident with tick -> count=load value, no step.
- en=0 across 3 ticks -> count frozen, tc=0, tick still pulses every 4 cycles. Reset asserted on a tick cycle -> count=0, no tc.
- UDC_SATURATE_EN defined, up from 8 -> 9, then held at 9 with tc=1 on each further tick. Down from 1 -> 0, then held.
